updown_counter_multidigit: RTL and testbench
============================================

Name: updown_counter_multidigit

Overview:
Parametrised multi-digit up/down counter. Each digit counts in a selectable radix (2..16) and is stored in its own 4-bit nibble. Adds synchronous parallel load, a wrap or saturate mode, optional rising-edge detection on the inc/dec controls, and wrap status outputs. Sits between debounced push-button inputs and the 7-segment display driver in the lab top level; the count bus feeds the per-digit decoders directly.

Parameters:
DIGITS, 2, number of digits, legal 1..8
RADIX, 16, radix of every digit, legal 2..16 (10 = BCD, 16 = hex)
EDGE_DETECT, 1, 1 = inc/dec act on rising edges only; 0 = act on every cycle they are high

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
inc  input  1  increment request
dec  input  1  decrement request
load  input  1  synchronous parallel load
load_value  input  4*DIGITS  load data, digit k in bits [4k+3:4k]
sat_mode  input  1  0 = wrap at the limits, 1 = saturate at the limits
count  output  4*DIGITS  current value, digit k in bits [4k+3:4k], digit 0 least significant
wrap_up  output  1  one-cycle pulse: count wrapped from max to zero
wrap_down  output  1  one-cycle pulse: count wrapped from zero to max
at_max  output  1  every digit equals RADIX-1
at_zero  output  1  every digit equals 0

Behaviour:
- Reset is asynchronous and active-high, with clock clk. Asserting reset forces: count = 0, wrap_up = 0, wrap_down = 0, edge-history registers (inc_q, dec_q) = 0. This applies at any time, including during a load or a cascade.
- Event qualification:
  - EDGE_DETECT=1: inc_ev = inc & ~inc_q and dec_ev = dec & ~dec_q. inc_q and dec_q sample inc and dec every cycle, regardless of load.
  - EDGE_DETECT=0: inc_ev = inc and dec_ev = dec.
  - After reset release, inc already high gives an inc_ev on the first clock edge (inc_q = 0).
- Priority, per clock edge:
  - load: count <= load_value, with each digit >= RADIX clamped to RADIX-1. Any coincident inc_ev/dec_ev is discarded. No wrap pulse.
  - else inc_ev & dec_ev: hold. No pulse.
  - else inc_ev: increment.
  - else dec_ev: decrement.
  - else hold.
- Increment: digit 0 +1. A digit at RADIX-1 becomes 0 and carries into the next digit (ripple through all DIGITS, same cycle).
  - At max with sat_mode=0: count becomes 0 and wrap_up = 1 for the next cycle.
  - At max with sat_mode=1: count holds and no pulse.
- Decrement: mirror of increment. A digit at 0 becomes RADIX-1 and borrows from the next digit.
  - At zero with sat_mode=0: count becomes all RADIX-1 and wrap_down = 1.
  - At zero with sat_mode=1: count holds.
- Latency:
  - count is visible one clock after the qualifying edge.
  - wrap_up/wrap_down are registered and asserted in the same cycle as the wrapped count. They are high for exactly one cycle, and cleared on any edge without a wrap.
  - at_max and at_zero are combinational from count.
- Digit values >= RADIX are unreachable by any path (reset, load clamp, arithmetic).
- sat_mode is sampled at the edge where it is used. Changing it has no other effect.
- With DIGITS=1 the block behaves as a single-digit counter. Nibble bits above the radix range always read 0 (e.g. RADIX=2 gives each nibble as 000x).

Test Plan:
- DIGITS=2, RADIX=10, EDGE_DETECT=0, sat_mode=0: reset, then inc high 100 cycles -> count steps 0x00..0x99 in BCD (0x09 -> 0x10 carry), then 0x00 with wrap_up high for exactly one cycle; at_max high while count=0x99.
- Same config: reset, dec one cycle -> count=0x99, wrap_down pulse one cycle; dec again -> 0x98 (0x90 -> 0x89 borrow checked).
- sat_mode=1: load 0x99, inc 3 cycles -> count stays 0x99, no wrap_up; load 0x00, dec 3 cycles -> stays 0x00, at_zero=1, no wrap_down.
- Load with clamp and priority: load_value=0x3F plus inc in the same cycle -> count=0x39; then inc and dec together for 4 cycles -> count stays 0x39.
- EDGE_DETECT=1, RADIX=16, DIGITS=2: inc held high 5 cycles -> count +1 only; inc low 1 cycle, then high -> +1 again (0x02); from 0x0F, one edge -> 0x10.
- Async reset: assert reset between clock edges with count=0x57 and inc active -> count=0x00 immediately, wrap pulses low; release reset with inc high (EDGE_DETECT=1) -> first edge gives 0x01.

Source files
------------

// File: rtl/updown_counter_multidigit.sv
// Multi-digit up/down counter, one nibble per digit, selectable radix, load/wrap/saturate.
// Latency: count and wrap pulses are registered one clock after the qualifying edge; at_max/at_zero are combinational.
// Backpressure: none; every inc/dec/load request is acted on in the cycle it qualifies.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   inc, dec           increment / decrement requests (edge- or level-qualified by EDGE_DETECT)
//   load, load_value   synchronous parallel load, digits >= RADIX clamped to RADIX-1
//   sat_mode           0 = wrap at the limits, 1 = saturate at the limits
//   count              current value, digit k in bits [4k+3:4k], digit 0 least significant
//   wrap_up/wrap_down  one-cycle pulses coincident with a wrapped count
//   at_max/at_zero     all digits at RADIX-1 / all digits at 0
module updown_counter_multidigit #(
    parameter int DIGITS      = 2,
    parameter int RADIX       = 16,
    parameter int EDGE_DETECT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  sat_mode,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap_up,
    output logic                  wrap_down,
    output logic                  at_max,
    output logic                  at_zero
);

    localparam logic [3:0] DMAX = 4'(RADIX - 1);
    localparam logic [4:0] RAD5 = 5'(RADIX);

    logic                inc_q;
    logic                dec_q;
    logic                inc_ev;
    logic                dec_ev;
    logic                carry;
    logic                borrow;
    logic [4*DIGITS-1:0] inc_val;
    logic [4*DIGITS-1:0] dec_val;
    logic [4*DIGITS-1:0] load_clamped;
    logic [4*DIGITS-1:0] count_nxt;
    logic                wrap_up_nxt;
    logic                wrap_down_nxt;

    // History registers sample every cycle so that a level held across a load
    // does not produce a fresh edge afterwards.
    assign inc_ev = (EDGE_DETECT != 0) ? (inc & ~inc_q) : inc;
    assign dec_ev = (EDGE_DETECT != 0) ? (dec & ~dec_q) : dec;

    always_comb begin
        at_max  = 1'b1;
        at_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (count[4*k +: 4] != DMAX) at_max  = 1'b0;
            if (count[4*k +: 4] != 4'd0) at_zero = 1'b0;
        end
    end

    // Ripple increment: digits at RADIX-1 roll to 0 and pass the carry on.
    // From all-max this naturally yields all-zero, which is the wrap value.
    always_comb begin
        inc_val = count;
        carry   = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (count[4*k +: 4] == DMAX) begin
                    inc_val[4*k +: 4] = 4'd0;
                end else begin
                    inc_val[4*k +: 4] = count[4*k +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // Ripple decrement: digits at 0 roll to RADIX-1 and pass the borrow on.
    always_comb begin
        dec_val = count;
        borrow  = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (borrow) begin
                if (count[4*k +: 4] == 4'd0) begin
                    dec_val[4*k +: 4] = DMAX;
                end else begin
                    dec_val[4*k +: 4] = count[4*k +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    always_comb begin
        load_clamped = load_value;
        for (int k = 0; k < DIGITS; k++) begin
            if ({1'b0, load_value[4*k +: 4]} >= RAD5) load_clamped[4*k +: 4] = DMAX;
        end
    end

    always_comb begin
        count_nxt     = count;
        wrap_up_nxt   = 1'b0;
        wrap_down_nxt = 1'b0;
        if (load) begin
            count_nxt = load_clamped;
        end else if (inc_ev && !dec_ev) begin
            if (!(at_max && sat_mode)) begin
                count_nxt   = inc_val;
                wrap_up_nxt = at_max;
            end
        end else if (dec_ev && !inc_ev) begin
            if (!(at_zero && sat_mode)) begin
                count_nxt     = dec_val;
                wrap_down_nxt = at_zero;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            wrap_up   <= 1'b0;
            wrap_down <= 1'b0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
        end else begin
            count     <= count_nxt;
            wrap_up   <= wrap_up_nxt;
            wrap_down <= wrap_down_nxt;
            inc_q     <= inc;
            dec_q     <= dec;
        end
    end

endmodule

// File: tb/tb_updown_counter_multidigit.sv
// Bench for updown_counter_multidigit: two instances (BCD level-triggered, hex edge-triggered).
// Latency: model advances one step per clock edge; outputs compared on the falling edge.
// Backpressure: not applicable.
module tb_updown_counter_multidigit;

    logic       clk;
    logic       reset;
    logic       inc_s  [2];
    logic       dec_s  [2];
    logic       load_s [2];
    logic [7:0] lv_s   [2];
    logic       sat_s  [2];
    logic [7:0] cnt_s  [2];
    logic       wu_s   [2];
    logic       wd_s   [2];
    logic       amax_s [2];
    logic       azero_s[2];

    int n_asserts = 0;
    int n_fail    = 0;

    // Instance 0: DIGITS=2, RADIX=10, level-qualified. Instance 1: DIGITS=2, RADIX=16, edge-qualified.
    updown_counter_multidigit #(.DIGITS(2), .RADIX(10), .EDGE_DETECT(0)) dut_a (
        .clk(clk), .reset(reset), .inc(inc_s[0]), .dec(dec_s[0]), .load(load_s[0]),
        .load_value(lv_s[0]), .sat_mode(sat_s[0]), .count(cnt_s[0]), .wrap_up(wu_s[0]),
        .wrap_down(wd_s[0]), .at_max(amax_s[0]), .at_zero(azero_s[0])
    );

    updown_counter_multidigit #(.DIGITS(2), .RADIX(16), .EDGE_DETECT(1)) dut_b (
        .clk(clk), .reset(reset), .inc(inc_s[1]), .dec(dec_s[1]), .load(load_s[1]),
        .load_value(lv_s[1]), .sat_mode(sat_s[1]), .count(cnt_s[1]), .wrap_up(wu_s[1]),
        .wrap_down(wd_s[1]), .at_max(amax_s[1]), .at_zero(azero_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the count is a plain integer in 0 .. RADIX^DIGITS-1.
    int m_r   [2] = '{10, 16};
    int m_e   [2] = '{0, 1};
    int m_max [2] = '{99, 255};
    int m_val [2];
    int m_wu  [2];
    int m_wd  [2];
    int m_incq[2];
    int m_decq[2];

    function automatic logic [31:0] to_bus(input int val, input int r);
        logic [31:0] b;
        int          v;
        b = '0;
        v = val;
        for (int k = 0; k < 8; k++) begin
            b[4*k +: 4] = 4'(v % r);
            v           = v / r;
        end
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_val[i]  = 0;
            m_wu[i]   = 0;
            m_wd[i]   = 0;
            m_incq[i] = 0;
            m_decq[i] = 0;
        end
    endtask

    task automatic model_edge(input int i);
        int ie, de, v, mult, d;
        ie = (m_e[i] != 0) ? int'(inc_s[i] && (m_incq[i] == 0)) : int'(inc_s[i]);
        de = (m_e[i] != 0) ? int'(dec_s[i] && (m_decq[i] == 0)) : int'(dec_s[i]);
        m_incq[i] = int'(inc_s[i]);
        m_decq[i] = int'(dec_s[i]);
        m_wu[i] = 0;
        m_wd[i] = 0;
        if (load_s[i]) begin
            v    = 0;
            mult = 1;
            for (int k = 0; k < 2; k++) begin
                d = int'(lv_s[i][4*k +: 4]);
                if (d >= m_r[i]) d = m_r[i] - 1;
                v    = v + d * mult;
                mult = mult * m_r[i];
            end
            m_val[i] = v;
        end else if (ie != 0 && de != 0) begin
            m_val[i] = m_val[i];
        end else if (ie != 0) begin
            if (m_val[i] == m_max[i]) begin
                if (!sat_s[i]) begin
                    m_val[i] = 0;
                    m_wu[i]  = 1;
                end
            end else begin
                m_val[i] = m_val[i] + 1;
            end
        end else if (de != 0) begin
            if (m_val[i] == 0) begin
                if (!sat_s[i]) begin
                    m_val[i] = m_max[i];
                    m_wd[i]  = 1;
                end
            end else begin
                m_val[i] = m_val[i] - 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_count%0d", tag, i), 32'(cnt_s[i]), to_bus(m_val[i], m_r[i]));
            chk($sformatf("%s_wrap_up%0d", tag, i), 32'(wu_s[i]), 32'(m_wu[i]));
            chk($sformatf("%s_wrap_down%0d", tag, i), 32'(wd_s[i]), 32'(m_wd[i]));
            chk($sformatf("%s_at_max%0d", tag, i), 32'(amax_s[i]), 32'(m_val[i] == m_max[i]));
            chk($sformatf("%s_at_zero%0d", tag, i), 32'(azero_s[i]), 32'(m_val[i] == 0));
        end
    endtask

    // One clock edge: inputs are already stable, model steps, outputs checked on the falling edge.
    task automatic tick(input string tag);
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int j = 0; j < n; j++) tick(tag);
    endtask

    // Reset asserted between edges and checked before the next edge arrives.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 model_reset();
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            inc_s[i]  = 1'b0;
            dec_s[i]  = 1'b0;
            load_s[i] = 1'b0;
            lv_s[i]   = 8'h00;
            sat_s[i]  = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();

        // Reset state
        do_reset("reset");
        tick("idle");

        // BCD count-up through full range, carry 0x09->0x10, wrap at 0x99
        inc_s[0] = 1'b1;
        ticks(100, "bcd_up");
        inc_s[0] = 1'b0;
        tick("bcd_up_wrap_clear");

        // Decrement from zero wraps to 0x99, then borrow down to 0x89
        do_reset("reset2");
        dec_s[0] = 1'b1;
        tick("bcd_dn_wrap");
        ticks(10, "bcd_dn_borrow");
        dec_s[0] = 1'b0;
        tick("bcd_dn_hold");

        // Saturation at both limits
        sat_s[0]  = 1'b1;
        load_s[0] = 1'b1;
        lv_s[0]   = 8'h99;
        tick("sat_load_max");
        load_s[0] = 1'b0;
        inc_s[0]  = 1'b1;
        ticks(3, "sat_up");
        inc_s[0]  = 1'b0;
        load_s[0] = 1'b1;
        lv_s[0]   = 8'h00;
        tick("sat_load_zero");
        load_s[0] = 1'b0;
        dec_s[0]  = 1'b1;
        ticks(3, "sat_dn");
        dec_s[0]  = 1'b0;
        sat_s[0]  = 1'b0;

        // Load clamp and priority over inc; then inc+dec together holds
        load_s[0] = 1'b1;
        lv_s[0]   = 8'h3F;
        inc_s[0]  = 1'b1;
        tick("load_clamp");
        load_s[0] = 1'b0;
        dec_s[0]  = 1'b1;
        ticks(4, "inc_dec_hold");
        inc_s[0]  = 1'b0;
        dec_s[0]  = 1'b0;

        // Edge detection on the hex instance
        inc_s[1] = 1'b1;
        ticks(5, "edge_held");
        inc_s[1] = 1'b0;
        tick("edge_low");
        inc_s[1] = 1'b1;
        tick("edge_again");
        inc_s[1]  = 1'b0;
        load_s[1] = 1'b1;
        lv_s[1]   = 8'h0F;
        tick("hex_load_0f");
        load_s[1] = 1'b0;
        inc_s[1]  = 1'b1;
        tick("hex_carry");
        inc_s[1]  = 1'b0;
        tick("hex_idle");

        // Async reset mid-cycle with inc active; release with inc high
        load_s[0] = 1'b1;
        lv_s[0]   = 8'h57;
        load_s[1] = 1'b1;
        lv_s[1]   = 8'h57;
        tick("load_57");
        load_s[0] = 1'b0;
        load_s[1] = 1'b0;
        inc_s[0]  = 1'b1;
        inc_s[1]  = 1'b1;
        do_reset("async_reset");
        inc_s[0]  = 1'b0;
        tick("post_reset_edge");
        inc_s[1]  = 1'b0;

        // Randomized traffic on both instances
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                inc_s[i]  = 1'($urandom_range(0, 1));
                dec_s[i]  = ($urandom_range(0, 3) == 0);
                load_s[i] = ($urandom_range(0, 15) == 0);
                lv_s[i]   = 8'($urandom);
                sat_s[i]  = ($urandom_range(0, 3) == 0);
            end
            tick("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
